// File: rtl/chroma_upsample_h_pkg.sv
// Shared definitions for the horizontal 4:2:2 -> 4:4:4 chroma upsampler.
package chroma_upsample_h_pkg;

  localparam int W   = 8;
  localparam int RND = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    WAIT = 2'd2,
    ODD  = 2'd3
  } state_t;

endpackage

// File: rtl/chroma_upsample_h_times3.sv
// Combinational multiply-by-three built from a single shift and add.
module chroma_times3 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W+1:0] y
);

  assign y = {1'b0, x, 1'b0} + {2'b00, x};

endmodule

// File: rtl/chroma_upsample_h.sv
// Streaming 1:2 horizontal chroma upsampler: each input sample produces an even
// output blended with its left neighbour and an odd output blended with its right.
module chroma_upsample_h
  import chroma_upsample_h_pkg::*;
#(
  parameter int W = chroma_upsample_h_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready
);

  state_t         state;
  logic [W-1:0]   prev;
  logic [W-1:0]   cur;
  logic [W-1:0]   nxt;
  logic           cur_last;
  logic           nxt_valid;
  logic           nxt_last;
  logic           out_valid_q;

  logic           in_fire;
  logic           out_fire;
  logic [W+1:0]   cur_x3;
  logic [W-1:0]   nb;
  logic [W+2:0]   sum;

  chroma_times3 #(.W(W)) u_times3 (
    .x (cur),
    .y (cur_x3)
  );

  // Ready depends only on registered state, so there is no combinational
  // loop through the upstream valid.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      EVEN:    in_ready = !cur_last && !nxt_valid;
      WAIT:    in_ready = 1'b1;
      ODD:     in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Odd outputs replicate cur at the right edge of a line.
  always_comb begin
    nb = prev;
    if (state == ODD) nb = cur_last ? cur : nxt;
  end

  assign sum       = {1'b0, cur_x3} + {3'b000, nb} + (W+3)'(RND);
  assign out_data  = out_valid_q ? W'(sum >> 2) : '0;
  assign out_valid = out_valid_q;
  assign out_last  = (state == ODD) && cur_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prev        <= '0;
      cur         <= '0;
      nxt         <= '0;
      cur_last    <= 1'b0;
      nxt_valid   <= 1'b0;
      nxt_last    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            cur         <= in_data;
            prev        <= in_data;
            cur_last    <= in_last;
            nxt_valid   <= 1'b0;
            state       <= EVEN;
            out_valid_q <= 1'b1;
          end
        end

        EVEN: begin
          if (in_fire) begin
            nxt       <= in_data;
            nxt_last  <= in_last;
            nxt_valid <= 1'b1;
          end
          if (out_fire) begin
            // Without a right neighbour in hand the odd output must wait.
            if (cur_last || nxt_valid || in_fire) begin
              state <= ODD;
            end else begin
              state       <= WAIT;
              out_valid_q <= 1'b0;
            end
          end
        end

        WAIT: begin
          if (in_fire) begin
            nxt         <= in_data;
            nxt_last    <= in_last;
            nxt_valid   <= 1'b1;
            state       <= ODD;
            out_valid_q <= 1'b1;
          end
        end

        ODD: begin
          if (out_fire) begin
            if (cur_last) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
            end else begin
              prev      <= cur;
              cur       <= nxt;
              cur_last  <= nxt_last;
              nxt_valid <= 1'b0;
              state     <= EVEN;
            end
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chroma_upsample_h.sv
// Self-checking bench for chroma_upsample_h against a per-line neighbour model.
module tb_chroma_upsample_h;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  always #5 clk = ~clk;

  chroma_upsample_h #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  logic [W-1:0] stim_data[$];
  logic         stim_last[$];
  logic [W-1:0] line_buf[$];
  logic [W-1:0] exp_data[$];
  logic         exp_last[$];
  logic [W-1:0] got_data[$];
  logic         got_last[$];
  int           got_cyc[$];
  int           acc_cyc[$];
  int           stall_viol;
  bit           timed_out;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic clear_all();
    stim_data.delete(); stim_last.delete(); line_buf.delete();
    exp_data.delete();  exp_last.delete();
  endtask

  // Expected outputs come straight from the per-line neighbour rule, edges replicated.
  task automatic push_sample(input logic [W-1:0] d, input bit last);
    int n, c, l, r;
    line_buf.push_back(d);
    stim_data.push_back(d);
    stim_last.push_back(last);
    if (last) begin
      n = line_buf.size();
      for (int i = 0; i < n; i++) begin
        c = int'(line_buf[i]);
        l = (i == 0)     ? c : int'(line_buf[i-1]);
        r = (i == n - 1) ? c : int'(line_buf[i+1]);
        exp_data.push_back(W'((3 * c + l + 2) / 4));
        exp_last.push_back(1'b0);
        exp_data.push_back(W'((3 * c + r + 2) / 4));
        exp_last.push_back(i == n - 1);
      end
      line_buf.delete();
    end
  endtask

  // Drives stim_* with random valid gaps and random out_ready until n_out outputs transfer.
  task automatic applyStimulus(input int ready_pct, input int valid_pct, input int n_out);
    int   idx = 0;
    int   cyc = 0;
    bit   in_fire, out_fire;
    bit   prev_stall = 1'b0;
    logic [W-1:0] prev_d = '0;
    logic prev_l = 1'b0;
    got_data.delete(); got_last.delete(); got_cyc.delete(); acc_cyc.delete();
    stall_viol = 0;
    timed_out  = 1'b0;
    in_valid  = (stim_data.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    in_data   = in_valid ? stim_data[0] : '0;
    in_last   = in_valid ? stim_last[0] : 1'b0;
    out_ready = ($urandom_range(0, 99) < ready_pct);
    while (got_data.size() < n_out) begin
      if (cyc > 3000) begin
        timed_out = 1'b1;
        break;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l))
        stall_viol++;
      in_fire    = in_valid && in_ready;
      out_fire   = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      if (out_fire) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_cyc.push_back(cyc);
      end
      if (in_fire) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!in_valid || in_fire) begin
        in_valid = (idx < stim_data.size()) && ($urandom_range(0, 99) < valid_pct);
        in_data  = in_valid ? stim_data[idx] : '0;
        in_last  = in_valid ? stim_last[idx] : 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("[TB] FAIL reset_out_data got=%0d want=0", out_data); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("[TB] FAIL reset_out_last got=%b want=0", out_last); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) $display("[TB] FAIL idle_in_ready got=%b want=1", in_ready); else n_pass++;
  endtask

  task automatic test_basic_line();
    clear_all();
    push_sample(8'd10, 1'b0); push_sample(8'd20, 1'b0); push_sample(8'd30, 1'b1);
    applyStimulus(100, 100, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL basic_timeout got=%0d outputs want=%0d", got_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL basic_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (got_cyc[0] !== acc_cyc[0] + 1) $display("[TB] FAIL basic_latency got=%0d want=%0d", got_cyc[0], acc_cyc[0] + 1); else n_pass++;
    n_checks++; if (got_cyc[5] - got_cyc[0] !== 5) $display("[TB] FAIL basic_no_gaps got=%0d want=5", got_cyc[5] - got_cyc[0]); else n_pass++;
  endtask

  task automatic test_single_sample();
    clear_all();
    push_sample(8'd200, 1'b1);
    applyStimulus(100, 100, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL single_timeout got=%0d want=2", got_data.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL single_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL single_back_to_idle got=%b%b want=10", in_ready, out_valid); else n_pass++;
  endtask

  task automatic test_max_and_edge();
    clear_all();
    push_sample(8'd255, 1'b0); push_sample(8'd255, 1'b0); push_sample(8'd0, 1'b1);
    applyStimulus(100, 100, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL maxedge_timeout got=%0d want=6", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL maxedge_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    for (int s = 1; s <= 4; s++) push_sample(W'(s), s == 4);
    applyStimulus(45, 100, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL bp_timeout got=%0d want=8", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL bp_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (stall_viol !== 0) $display("[TB] FAIL bp_stall_stable got=%0d changes want=0", stall_viol); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_all();
    push_sample(8'd5, 1'b0); push_sample(8'd9, 1'b1); push_sample(8'd100, 1'b1);
    applyStimulus(100, 100, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL b2b_timeout got=%0d want=6", got_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL b2b_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++;
    if (!(acc_cyc[2] > got_cyc[3]))
      $display("[TB] FAIL b2b_hold_next_line got=accept@%0d want=after %0d", acc_cyc[2], got_cyc[3]);
    else n_pass++;
  endtask

  task automatic test_random_lines();
    int len;
    clear_all();
    for (int l = 0; l < 5; l++) begin
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) push_sample(W'($urandom_range(0, 255)), s == len - 1);
    end
    applyStimulus(55, 65, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL rand_timeout got=%0d want=%0d", got_data.size(), exp_data.size()); else n_pass++;
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL rand_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
    n_checks++; if (stall_viol !== 0) $display("[TB] FAIL rand_stall_stable got=%0d changes want=0", stall_viol); else n_pass++;
  endtask

  task automatic test_reset_mid_line();
    clear_all();
    push_sample(8'd40, 1'b0); push_sample(8'd50, 1'b0); push_sample(8'd60, 1'b0); push_sample(8'd70, 1'b1);
    applyStimulus(100, 100, 3);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("[TB] FAIL midrst_pre_valid got=%b want=1", out_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_async_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("[TB] FAIL midrst_in_ready got=%b want=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_all();
    push_sample(8'd7, 1'b1);
    applyStimulus(100, 100, exp_data.size());
    n_checks++; if (timed_out) $display("[TB] FAIL midrst_timeout got=%0d want=2", got_data.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
        $display("[TB] FAIL midrst_out%0d got=%0d/%b want=%0d/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_single_sample();
    test_max_and_edge();
    test_backpressure();
    test_back_to_back();
    test_random_lines();
    test_reset_mid_line();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL global_watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
